demux_stream_1ton: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer. It routes a valid/ready input stream to one of N output channels, each with a one-entry holding register and independent backpressure. Channel selection is either addressed (per-beat select) or round-robin (internal pointer). This is the sequential successor to the combinational 1-to-8 demux, for fan-out of data streams to downstream consumers.

---
 rtl/demux_stream_1ton.sv | 99 +++++++++
 tb/tb_demux_stream_1ton.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer: one holding register per output channel,
// addressed or round-robin channel selection, saturating count of out-of-range drops.
module demux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 mode,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [SELW-1:0]      rr_ptr,
    output logic [7:0]           err_cnt
);
    localparam int NP = 1 << SELW;
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d, target;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [N-1:0]     valid_q, valid_d, load;
    logic [WIDTH-1:0] data_q [N];
    logic [NP-1:0]    valid_pad, ready_pad, range_pad;
    logic             in_range, accept;

    assign target = mode ? rr_ptr_q : in_sel;

    // Pad per-channel flags out to the full select space so any select value indexes safely.
    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_pad
            if (gi < N) begin : g_real
                assign valid_pad[gi] = valid_q[gi];
                assign ready_pad[gi] = out_ready[gi];
                assign range_pad[gi] = 1'b1;
            end else begin : g_void
                assign valid_pad[gi] = 1'b0;
                assign ready_pad[gi] = 1'b0;
                assign range_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign in_range = range_pad[target];
    assign in_ready = !in_range || !valid_pad[target] || ready_pad[target];
    assign accept   = in_valid && in_ready;

    // A load on a draining channel keeps valid high, giving back-to-back throughput.
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign load[gi]    = accept && in_range && (target == SELW'(gi));
            assign valid_d[gi] = load[gi] || (valid_q[gi] && !out_ready[gi]);
            assign out_data[gi*WIDTH +: WIDTH] = data_q[gi];
        end
    endgenerate

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && mode) begin
            rr_ptr_d = (rr_ptr_q == LAST) ? '0 : rr_ptr_q + SELW'(1);
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !in_range && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            err_cnt_q <= '0;
            valid_q   <= '0;
            for (int k = 0; k < N; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            err_cnt_q <= err_cnt_d;
            valid_q   <= valid_d;
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign rr_ptr    = rr_ptr_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: per-channel expectation queues fed on accept and drained
// on output handshake, plus a vector table and directed corner-case sequences.
module tb_demux_stream_1ton;
    localparam int W = 8;
    localparam int N = 8;
    localparam int S = 3;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]   in_data;
    logic           in_valid, in_ready, mode;
    logic [S-1:0]   in_sel;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid, out_ready;
    logic [S-1:0]   rr_ptr;
    logic [7:0]     err_cnt;

    logic [W-1:0]    in_data6;
    logic            in_valid6, in_ready6, mode6;
    logic [S-1:0]    in_sel6;
    logic [N6*W-1:0] out_data6;
    logic [N6-1:0]   out_valid6, out_ready6;
    logic [S-1:0]    rr_ptr6;
    logic [7:0]      err_cnt6;

    demux_stream_1ton #(.WIDTH(W), .N(N), .SELW(S)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .rr_ptr(rr_ptr), .err_cnt(err_cnt)
    );

    demux_stream_1ton #(.WIDTH(W), .N(N6), .SELW(S)) dut6 (
        .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_sel(in_sel6), .mode(mode6), .out_data(out_data6), .out_valid(out_valid6),
        .out_ready(out_ready6), .rr_ptr(rr_ptr6), .err_cnt(err_cnt6)
    );

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] data;
        logic       vld;
        logic [7:0] ordy;
        logic       exp_rdy;
    } vec_t;

    vec_t       tbl [15];
    logic [7:0] expq [N][$];
    logic [7:0] lastd [N];
    int         exp_rr = 0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            expq[k].delete();
            lastd[k] = '0;
        end
        exp_rr = 0;
    endtask

    // One clock of the main DUT: check at negedge, update model, return at posedge+1.
    task automatic cycle(input int tbl_rdy);
        int t;
        logic exp_rdy;
        logic [7:0] front;
        @(negedge clk);
        t = mode ? exp_rr : int'(in_sel);
        exp_rdy = (t >= N) ? 1'b1 : ((expq[t].size() == 0) || out_ready[t]);
        chk("in_ready", in_ready, exp_rdy);
        if (tbl_rdy >= 0) chk("tbl_in_ready", in_ready, tbl_rdy[0]);
        chk("rr_ptr", rr_ptr, exp_rr);
        chk("err_cnt", err_cnt, 0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("out_valid[%0d]", k), out_valid[k], expq[k].size() != 0);
            chk($sformatf("out_data[%0d]", k), out_data[k*W +: W], lastd[k]);
            if (expq[k].size() != 0 && out_ready[k]) begin
                front = expq[k].pop_front();
                chk($sformatf("drain[%0d]", k), out_data[k*W +: W], front);
                $display("drain ch=%0d data=%02h", k, out_data[k*W +: W]);
            end
        end
        if (in_valid && exp_rdy) begin
            if (t < N) begin
                expq[t].push_back(in_data);
                lastd[t] = in_data;
            end
            if (mode) exp_rr = (exp_rr == N - 1) ? 0 : exp_rr + 1;
            $display("accept ch=%0d data=%02h mode=%0d", t, in_data, mode);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input int sel, input logic [7:0] d, input logic v);
        mode = m;
        in_sel = S'(sel);
        in_data = d;
        in_valid = v;
    endtask

    initial begin
        for (int k = 0; k < 8; k++)
            tbl[k] = '{mode: 1'b0, sel: 3'(k), data: 8'hA0 + 8'(k), vld: 1'b1, ordy: 8'hFF, exp_rdy: 1'b1};
        tbl[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 1'b1};
        tbl[9]  = '{1'b0, 3'd3, 8'h11, 1'b1, 8'hF7, 1'b1};
        tbl[10] = '{1'b0, 3'd3, 8'h55, 1'b1, 8'hF7, 1'b0};
        tbl[11] = '{1'b0, 3'd4, 8'h22, 1'b1, 8'hF7, 1'b1};
        tbl[12] = '{1'b0, 3'd3, 8'h33, 1'b1, 8'hFF, 1'b1};
        tbl[13] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 1'b1};
        tbl[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 1'b1};

        drive(1'b0, 0, 8'h00, 1'b0);
        out_ready = '1;
        in_data6 = '0; in_valid6 = 1'b0; in_sel6 = '0; mode6 = 1'b0; out_ready6 = '1;
        clear_model();

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rr_ptr", rr_ptr, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Addressed sweep and backpressure from the vector table.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].mode, int'(tbl[i].sel), tbl[i].data, tbl[i].vld);
            out_ready = tbl[i].ordy;
            cycle(int'(tbl[i].exp_rdy));
        end

        // Round-robin: ten beats, then a mode-0 interlude, then resume.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 0, 8'hC0 + 8'(i), 1'b1);
            cycle(1);
        end
        chk("rr_after_10", rr_ptr, 2);
        drive(1'b0, 5, 8'hD0, 1'b1); cycle(1);
        drive(1'b0, 6, 8'hD1, 1'b1); cycle(1);
        chk("rr_held", rr_ptr, 2);
        drive(1'b1, 0, 8'hE0, 1'b1); cycle(1);
        chk("rr_resume_valid", out_valid[2], 1);
        chk("rr_resume_data", out_data[2*W +: W], 8'hE0);
        drive(1'b0, 0, 8'h00, 1'b0); cycle(-1);

        // Stall isolation: channel 0 held while channels 1 and 2 stream.
        out_ready = 8'hFE;
        drive(1'b0, 0, 8'h77, 1'b1); cycle(1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, (i % 2 == 1) ? 2 : 1, 8'h80 + 8'(i), 1'b1);
            cycle(1);
        end
        chk("stall_ch0_valid", out_valid[0], 1);
        chk("stall_ch0_data", out_data[0 +: W], 8'h77);
        drive(1'b0, 0, 8'h00, 1'b0);
        out_ready = 8'hFF;
        cycle(-1);
        cycle(-1);
        chk("stall_ch0_drained", out_valid[0], 0);
        chk("stall_ch0_hold", out_data[0 +: W], 8'h77);

        // Mid-run reset with channels 2 and 5 full.
        out_ready = 8'hDB;
        drive(1'b0, 2, 8'hF2, 1'b1); cycle(1);
        drive(1'b0, 5, 8'hF5, 1'b1); cycle(1);
        drive(1'b0, 0, 8'h00, 1'b0); cycle(-1);
        chk("pre_rst_full", out_valid, 8'h24);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_rr_ptr", rr_ptr, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        clear_model();
        out_ready = 8'hFF;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 4, 8'h99, 1'b1);
        chk("post_rst_in_ready", in_ready, 1);
        cycle(1);
        drive(1'b0, 0, 8'h00, 1'b0);
        cycle(-1);
        chk("post_rst_ch0", out_data[0 +: W], 8'h99);

        // Out-of-range drops on the N=6 instance.
        for (int i = 0; i < 300; i++) begin
            in_valid6 = 1'b1;
            in_sel6 = 3'd7;
            in_data6 = 8'(i);
            @(negedge clk);
            chk("oor_in_ready", in_ready6, 1);
            chk("oor_out_valid", out_valid6, 0);
            chk("oor_err_cnt", err_cnt6, (i > 255) ? 255 : i);
            $display("drop beat=%0d err_cnt=%0d", i, err_cnt6);
            @(posedge clk);
            #1;
        end
        in_valid6 = 1'b0;
        chk("oor_err_sat", err_cnt6, 255);
        chk("oor_rr_ptr", rr_ptr6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
